// File: rtl/interrupt_capture.sv
// -----------------------------------------------------------------------------
// interrupt_capture
//
// Front end of the interrupt path. Each raw peripheral line is brought into the
// clk domain through a two-flop synchroniser, debounced by a per-line counter,
// then gated by a per-line enable mask and turned into a request bit for the
// interrupt request/attention manager: a single-cycle pulse per accepted rising
// transition (edge mode) or a sustained request while the debounced line is
// high (level mode).
//
// Parameters
//   WIDTH     number of interrupt lines (bit 0 = highest priority downstream)
//   DEBOUNCE  consecutive synchronised cycles a new level must hold before it
//             is accepted (1..255)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   irq_in    raw asynchronous interrupt lines, active high
//   we_mask   load mask_q from mask_in at this edge
//   mask_in   new enable mask, 1 = line enabled
//   we_mode   load mode_q from mode_in at this edge
//   mode_in   new per-line mode, 1 = rising edge, 0 = level
//   int_e     registered request bits to the interrupt manager
//   mask_q    current enable mask
//   mode_q    current mode
//   irq_stat  debounced line state, unmasked, for software polling
// -----------------------------------------------------------------------------
module interrupt_capture #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] irq_in,
  input  logic             we_mask,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             we_mode,
  input  logic [WIDTH-1:0] mode_in,
  output logic [WIDTH-1:0] int_e,
  output logic [WIDTH-1:0] mask_q,
  output logic [WIDTH-1:0] mode_q,
  output logic [WIDTH-1:0] irq_stat
);

  // Counter value on which a still-disagreeing line is accepted: the current
  // cycle is the DEBOUNCE-th consecutive disagreement.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [7:0]       cnt_q [WIDTH];

  logic [7:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] stat_d;
  logic [WIDTH-1:0] int_d;

  // ---------------------------------------------------------------------------
  // Debounce and request generation. Mask and mode are the registered values,
  // so a config write at the same edge only influences the following edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    update = '0;
    stat_d = irq_stat;
    int_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != irq_stat[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          update[i] = 1'b1;
          stat_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
      // Edge mode fires only on an accepted rise; level mode follows the
      // debounced state including any update happening at this edge.
      if (mode_q[i]) begin
        int_d[i] = mask_q[i] & update[i] & s2_q[i];
      end else begin
        int_d[i] = mask_q[i] & stat_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      irq_stat <= '0;
      int_e    <= '0;
      mask_q   <= '0;
      mode_q   <= '1;
      // NOTE: the counter array is reset element by element; it is a handful of
      // flops, not a RAM, and a partial count must not survive a reset.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep s2_q reading the old s1_q, which is
      // what makes this a two-stage synchroniser rather than a wire.
      s1_q     <= irq_in;
      s2_q     <= s1_q;
      irq_stat <= stat_d;
      int_e    <= int_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (we_mask) begin
        mask_q <= mask_in;
      end
      if (we_mode) begin
        mode_q <= mode_in;
      end
    end
  end

endmodule

// File: doc/interrupt_capture.md
Name: interrupt_capture

Overview:
- Front end of the interrupt path. Takes raw asynchronous peripheral interrupt lines, synchronises and debounces them, applies per-line enable mask and edge/level mode, and drives registered one-cycle (edge) or sustained (level) request bits.
- Its output feeds the int_e input of the interrupt request/attention manager.
- Mask and mode registers are written by the CPU datapath.

Parameters:
- WIDTH, 8, number of interrupt lines; bit 0 = highest priority downstream.
- DEBOUNCE, 4, consecutive synchronised cycles a new level must hold before it is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_in  input  WIDTH  raw asynchronous interrupt lines, active high.
- we_mask  input  1  load mask_q from mask_in at this edge.
- mask_in  input  WIDTH  new enable mask; 1 = line enabled.
- we_mode  input  1  load mode_q from mode_in at this edge.
- mode_in  input  WIDTH  new mode per line; 1 = rising-edge, 0 = level.
- int_e  output  WIDTH  registered request bits to the interrupt manager.
- mask_q  output  WIDTH  current enable mask.
- mode_q  output  WIDTH  current mode.
- irq_stat  output  WIDTH  debounced line state, unmasked, for software polling.

Behaviour:
- Reset (reset=0, asynchronous) clears everything below; the block resumes at the first clk edge after reset returns to 1:
  - sync stage 1 and stage 2, debounce counters, irq_stat: all 0.
  - int_e = 0.
  - mask_q = 0 (all lines disabled).
  - mode_q = all ones (edge mode).
- Synchroniser: two flops per line, s1 <= irq_in, s2 <= s1. Only s2 is used downstream.
- Debounce, per line, 8-bit counter cnt, stable state irq_stat:
  - s2 == irq_stat: cnt <= 0.
  - s2 != irq_stat and cnt == DEBOUNCE-1: irq_stat <= s2, cnt <= 0. This is the "update" event.
  - Otherwise: cnt <= cnt+1.
  - Any disagreement shorter than DEBOUNCE cycles is discarded and leaves irq_stat unchanged.
- Request generation, registered at the same edge as the debounce evaluation, using mask_q/mode_q values before any write at that edge:
  - Edge mode: int_e[i] <= mask_q[i] & update[i] & s2[i]. One cycle high per accepted rising transition. Falling transitions produce nothing.
  - Level mode: int_e[i] <= mask_q[i] & irq_stat_next[i]. High every cycle while the debounced line is high.
- Latency: irq_in high and stable before edge k (sampled into s1 at edge k) → irq_stat and int_e (edge mode) high after edge k+1+DEBOUNCE. In edge mode int_e drops after the following edge.
- Config writes: we_mask and we_mode are independent and may occur in the same cycle. A new value takes effect for int_e computation from the next edge.
- Masked events are lost: an edge accepted while mask_q[i]=0 is not held pending and is not replayed when the line is later enabled.
  - Level-mode lines still high when enabled assert int_e one cycle after the mask write.
- Mode change edge→level while irq_stat[i]=1 asserts int_e[i] from the next edge. Level→edge deasserts it from the next edge, with no extra pulse.
- Lines are fully independent. Simultaneous events on several lines produce simultaneous int_e bits; prioritisation is done downstream.
- Reset mid-debounce discards partial counts. A line held high through reset is re-accepted as a new rising edge after DEBOUNCE+2 edges.

Test Plan:
- Reset default: reset=0, then 1; irq_in=8'hFF for 20 cycles with mask_q=0 → int_e stays 8'h00 and irq_stat=8'hFF after edge 5.
- Edge mode, DEBOUNCE=4: mask=8'h04, irq_in[2] rises before edge 0 and holds → int_e=8'h04 for exactly one cycle (after edge 5, cleared after edge 6). No further pulses while held; falling edge gives no pulse.
- Glitch rejection: irq_in[0] high for 3 cycles then low, mask=8'hFF → irq_stat[0] never set, int_e stays 0. A 4-cycle pulse (post-sync) gives exactly one int_e[0] pulse.
- Level mode: mode=8'h00, mask=8'h81, irq_in=8'h81 held for 10 cycles → int_e=8'h81 continuously from edge 5 until 5 edges after release.
- Mask write ordering: accepted rising edge on line 1 in the same cycle we_mask sets mask_in=8'h02 from 0 → no pulse (old mask used) and no later pulse. Next clean edge → pulse.
- Async reset mid-operation: assert reset while int_e=8'h10 and counters mid-count → int_e=0, mask_q=0, mode_q=8'hFF immediately, without waiting for clk.
